// File: rtl/iiitb_vend_pkg.sv
// Shared definitions for the vending FSM and the coin scheduler:
// coin codes, vending FSM state codes, scheduler states and coin validity.
package iiitb_vend_pkg;

    // Coin codes as seen on the vending FSM coin input
    localparam logic [2:0] NICKEL      = 3'b001;
    localparam logic [2:0] DIME        = 3'b010;
    localparam logic [2:0] NICKEL_DIME = 3'b011;
    localparam logic [2:0] DIME_DIME   = 3'b100;
    localparam logic [2:0] QUARTER     = 3'b101;

    // Vending FSM state codes
    localparam logic [2:0] IDLE       = 3'b000;
    localparam logic [2:0] FIVE       = 3'b001;
    localparam logic [2:0] TEN        = 3'b010;
    localparam logic [2:0] FIFTEEN    = 3'b011;
    localparam logic [2:0] TWENTY     = 3'b100;
    localparam logic [2:0] TWENTYFIVE = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_VEND_WAIT
    } sched_state_e;

    // Only single physical coins may be offered by an acceptor
    function automatic logic coin_valid(input logic [2:0] coin);
        return (coin == NICKEL) || (coin == DIME) || (coin == QUARTER);
    endfunction

endpackage

// File: rtl/iiitb_coin_sched_if.sv
// Bundle between coin acceptors / vending FSM (master side) and the scheduler (slave side).
interface iiitb_coin_sched_if #(
    parameter int unsigned NUM_SLOTS = 4
) ();
    localparam int unsigned IDX_W = $clog2(NUM_SLOTS);

    logic [NUM_SLOTS-1:0]   slot_valid;
    logic [3*NUM_SLOTS-1:0] slot_coin;
    logic [NUM_SLOTS-1:0]   slot_ready;
    logic [NUM_SLOTS-1:0]   slot_reject;
    logic [2:0]             fsm_coin;
    logic [2:0]             fsm_state;
    logic                   fsm_vend;
    logic [IDX_W-1:0]       grant_id;
    logic                   busy;
    logic                   fault;

    modport master (
        output slot_valid, slot_coin, fsm_state, fsm_vend,
        input  slot_ready, slot_reject, fsm_coin, grant_id, busy, fault
    );

    modport slave (
        input  slot_valid, slot_coin, fsm_state, fsm_vend,
        output slot_ready, slot_reject, fsm_coin, grant_id, busy, fault
    );
endinterface

// File: rtl/iiitb_rr_arbiter.sv
// Round-robin arbiter: searches from the slot after the last grant; the
// pointer only moves when the caller strobes advance.
module iiitb_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index
);
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             found;
    int unsigned      cand;

    // Pick the first requester at or after the pointer, wrapping around
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = IDX_W'(cand);
            end
        end
    end

    // Next pointer is the slot after the one just granted
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (32'(index) == NUM_REQ - 1) ? '0 : index + 1'b1;
        end
    end

    // Pointer register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/iiitb_coin_sched.sv
// Coin scheduler: shares the vending FSM coin input among NUM_SLOTS acceptors.
// Optional: define IIITB_COIN_SCHED_LOCK_EN so that the first slot granted
// while the FSM is idle owns the purchase until the vend completes or times out.
module iiitb_coin_sched
    import iiitb_vend_pkg::*;
#(
    parameter int unsigned NUM_SLOTS    = 4,
    parameter int unsigned VEND_TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset_n,
    iiitb_coin_sched_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_SLOTS);

    sched_state_e         state_q, state_d;
    logic [2:0]           code_q, code_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 fault_q, fault_d;
    logic [IDX_W-1:0]     gid_q, gid_d;
    logic [NUM_SLOTS-1:0] mask, req, gnt;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 gnt_any, gnt_ok;
    logic [2:0]           gnt_coin;

`ifdef IIITB_COIN_SCHED_LOCK_EN
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] owner_q, owner_d;

    // While locked only the owning slot may be granted
    always_comb begin
        mask = '1;
        if (lock_q) begin
            mask          = '0;
            mask[owner_q] = 1'b1;
        end
    end

    // Take ownership on an accepted coin at FSM idle; release when the vend wait ends.
    // A rejected coin never takes ownership, otherwise it could lock out everyone.
    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        if (state_q == S_IDLE && gnt_any && gnt_ok && !lock_q && bus.fsm_state == IDLE) begin
            lock_d  = 1'b1;
            owner_d = gnt_idx;
        end
        if (state_q == S_VEND_WAIT && state_d == S_IDLE) begin
            lock_d = 1'b0;
        end
    end

    // Ownership registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lock_q  <= 1'b0;
            owner_q <= '0;
        end else begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
        end
    end
`else
    assign mask = '1;
`endif

    // Grants only in S_IDLE; reset_n gating keeps slot_ready low while reset is held
    assign req      = (state_q == S_IDLE && reset_n) ? (bus.slot_valid & mask) : '0;
    assign gnt_any  = |gnt;
    assign gnt_coin = bus.slot_coin[3*gnt_idx +: 3];
    assign gnt_ok   = coin_valid(gnt_coin);

    iiitb_rr_arbiter #(
        .NUM_REQ (NUM_SLOTS),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req),
        .advance (gnt_any),
        .grant   (gnt),
        .index   (gnt_idx)
    );

    // Scheduler next state, coin latch, vend timeout and fault
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        gid_d   = gid_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_any) begin
                    gid_d = gnt_idx;
                    if (gnt_ok) begin
                        code_d  = gnt_coin;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                // FSM has had one edge to react to the coin
                if (bus.fsm_state == TWENTYFIVE || bus.fsm_vend) begin
                    state_d = S_VEND_WAIT;
                    cnt_d   = 8'(VEND_TIMEOUT);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_VEND_WAIT: begin
                if (bus.fsm_state == IDLE) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) begin
                        fault_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            code_q  <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            gid_q   <= gid_d;
        end
    end

    // Outputs; busy also covers the cycle a valid coin is being accepted
    always_comb begin
        bus.slot_ready  = gnt;
        bus.slot_reject = (gnt_any && !gnt_ok) ? gnt : '0;
        bus.fsm_coin    = (state_q == S_ISSUE) ? code_q : 3'b000;
        bus.grant_id    = gid_q;
        bus.busy        = (state_q != S_IDLE) || (gnt_any && gnt_ok);
        bus.fault       = fault_q;
    end
endmodule
